// File: rtl/uart_core.sv
// ---------------------------------------------------------------------------
// uart_core
// Minimal UART transmitter and receiver running at one bit per clock cycle.
// There is no baud divider and no oversampling. TX and RX are independent.
//
// Frame on the line: start (0), data LSB first, optional parity, stop (1).
//
// Parameters
//   DATA_BITS  : payload bits per frame (5..9)
//   PARITY_BIT : "none", "even" or "odd"
//   STOP_BITS  : stop bits transmitted (1 or 2)
//
// Ports
//   i_clk             : clock; every register updates on the rising edge
//   i_rst_n           : asynchronous active-low reset
//   i_tx_data         : payload, latched on the edge that accepts a request
//   i_transmit_start  : transmit request
//   o_transmit_ready  : transmitter can accept a request on this edge
//   o_tx              : serial out, idle high, registered
//   o_rx_data         : payload of the last completed received frame
//   o_rx_data_valid   : o_rx_data holds a completed frame
//   o_rx_error        : the completed frame had a parity (or framing) fault
//   i_rx              : serial in, idle high
//
// Optional feature
//   `define UART_FRAMING_CHECK_EN : a 0 sampled as the stop bit also raises
//   o_rx_error. Without it the stop-bit sample is ignored.
// ---------------------------------------------------------------------------
module uart_core #(
    parameter int    DATA_BITS  = 8,
    parameter string PARITY_BIT = "even",
    parameter int    STOP_BITS  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_transmit_start,
    output logic                 o_transmit_ready,
    output logic                 o_tx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_data_valid,
    output logic                 o_rx_error,
    input  logic                 i_rx
);

    localparam bit             PAR_EN   = (PARITY_BIT != "none");
    localparam bit             PAR_ODD  = (PARITY_BIT == "odd");
    localparam int             CW       = $clog2(DATA_BITS);
    localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_BITS - 1);

    // Shared parity primitive: XNOR-reduction of the payload.
    function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
        return ~^d;
    endfunction

    // Even mode sends XOR of the data, odd mode sends XNOR.
    function automatic logic f_par_bit(input logic [DATA_BITS-1:0] d);
        return PAR_ODD ? f_parity(d) : ~f_parity(d);
    endfunction

    // -----------------------------------------------------------------------
    // Transmitter
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    tx_state_t            r_tx_state;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic [CW-1:0]        r_tx_cnt;
    logic                 r_tx_par;
    logic                 r_tx;
    logic                 r_tx_ready;
    logic                 w_tx_accept;

    assign w_tx_accept = i_transmit_start & r_tx_ready;

    // Each state names the bit currently on the line; r_tx is loaded with
    // the value of the state being entered so the output stays registered.
    // r_tx_ready is high in IDLE and in the last stop-bit cycle, so a
    // request there goes straight to LOAD (one idle cycle between frames).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
        end else begin
            unique case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_accept) begin
                        r_tx_shift <= i_tx_data;
                        r_tx_par   <= f_par_bit(i_tx_data);
                        r_tx_ready <= 1'b0;
                        r_tx_state <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    r_tx       <= 1'b0;
                    r_tx_state <= TX_START;
                end
                TX_START: begin
                    r_tx       <= r_tx_shift[0];
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_cnt   <= '0;
                    r_tx_state <= TX_DATA;
                end
                TX_DATA: begin
                    if (r_tx_cnt == LAST_BIT) begin
                        if (PAR_EN) begin
                            r_tx       <= r_tx_par;
                            r_tx_state <= TX_PARITY;
                        end else begin
                            r_tx       <= 1'b1;
                            r_tx_ready <= (STOP_BITS == 1);
                            r_tx_state <= TX_STOP;
                        end
                    end else begin
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_cnt   <= r_tx_cnt + 1'b1;
                    end
                end
                TX_PARITY: begin
                    r_tx       <= 1'b1;
                    r_tx_ready <= (STOP_BITS == 1);
                    r_tx_state <= TX_STOP;
                end
                TX_STOP: begin
                    // Ready doubles as the "last stop bit" marker.
                    if (r_tx_ready) begin
                        if (w_tx_accept) begin
                            r_tx_shift <= i_tx_data;
                            r_tx_par   <= f_par_bit(i_tx_data);
                            r_tx_ready <= 1'b0;
                            r_tx_state <= TX_LOAD;
                        end else begin
                            r_tx_state <= TX_IDLE;
                        end
                    end else begin
                        r_tx_ready <= 1'b1;
                    end
                end
                default: begin
                    r_tx       <= 1'b1;
                    r_tx_ready <= 1'b1;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign o_tx             = r_tx;
    assign o_transmit_ready = r_tx_ready;

    // -----------------------------------------------------------------------
    // Receiver
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    rx_state_t            r_rx_state;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic [CW-1:0]        r_rx_cnt;
    logic                 r_rx_par;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rx_err;
    logic                 w_rx_par_err;
    logic                 w_rx_frm_err;

    assign w_rx_par_err = PAR_EN && (r_rx_par != f_par_bit(r_rx_shift));

`ifdef UART_FRAMING_CHECK_EN
    assign w_rx_frm_err = ~i_rx;
`else
    assign w_rx_frm_err = 1'b0;
`endif

    // Only the first stop bit is sampled; later ones look like idle line.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_shift <= '0;
            r_rx_cnt   <= '0;
            r_rx_par   <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            unique case (r_rx_state)
                RX_IDLE: begin
                    if (!i_rx) begin
                        r_rx_cnt   <= '0;
                        r_rx_valid <= 1'b0;
                        r_rx_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    // LSB arrives first, so shift in from the top.
                    r_rx_shift <= {i_rx, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_cnt == LAST_BIT) begin
                        if (PAR_EN) r_rx_state <= RX_PARITY;
                        else        r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    r_rx_par   <= i_rx;
                    r_rx_state <= RX_STOP;
                end
                RX_STOP: begin
                    r_rx_data  <= r_rx_shift;
                    r_rx_valid <= 1'b1;
                    r_rx_err   <= w_rx_par_err | w_rx_frm_err;
                    r_rx_state <= RX_IDLE;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign o_rx_data       = r_rx_data;
    assign o_rx_data_valid = r_rx_valid;
    assign o_rx_error      = r_rx_err;

endmodule

// File: tb/tb_uart_core.sv
module tb_uart_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef UART_FRAMING_CHECK_EN
    localparam bit FRM_EN = 1'b1;
`else
    localparam bit FRM_EN = 1'b0;
`endif

    // Instance 0: defaults, 1: STOP_BITS=2, 2: odd parity, 3: no parity
    logic [3:0][7:0] txd;
    logic [3:0]      tstart;
    logic [3:0]      lb;
    logic            rx_drv;
    wire  [3:0]      tready, txo, rvalid, rerr, rxi;
    wire  [3:0][7:0] rdata;

    assign rxi = (lb & txo) | (~lb & {4{rx_drv}});

    int checks = 0;
    int fails  = 0;

    uart_core u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(txd[0]), .i_transmit_start(tstart[0]),
        .o_transmit_ready(tready[0]), .o_tx(txo[0]), .o_rx_data(rdata[0]),
        .o_rx_data_valid(rvalid[0]), .o_rx_error(rerr[0]), .i_rx(rxi[0]));
    uart_core #(.STOP_BITS(2)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(txd[1]), .i_transmit_start(tstart[1]),
        .o_transmit_ready(tready[1]), .o_tx(txo[1]), .o_rx_data(rdata[1]),
        .o_rx_data_valid(rvalid[1]), .o_rx_error(rerr[1]), .i_rx(rxi[1]));
    uart_core #(.PARITY_BIT("odd")) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(txd[2]), .i_transmit_start(tstart[2]),
        .o_transmit_ready(tready[2]), .o_tx(txo[2]), .o_rx_data(rdata[2]),
        .o_rx_data_valid(rvalid[2]), .o_rx_error(rerr[2]), .i_rx(rxi[2]));
    uart_core #(.PARITY_BIT("none")) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(txd[3]), .i_transmit_start(tstart[3]),
        .o_transmit_ready(tready[3]), .o_tx(txo[3]), .o_rx_data(rdata[3]),
        .o_rx_data_valid(rvalid[3]), .o_rx_error(rerr[3]), .i_rx(rxi[3]));

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stp;
        logic       exp_perr;
        logic       exp_ferr;
    } rx_vec_t;

    typedef struct {
        logic [7:0]  d;
        logic [10:0] frame;   // first bit on the line is the MSB
    } tx_vec_t;

    rx_vec_t rxv[7];
    tx_vec_t txv[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Issue one request on instance u and capture nb line bits after LOAD.
    task automatic tx_frame(input int u, input logic [7:0] d, input int nb,
                            output logic [15:0] cap);
        @(negedge clk);
        chk("ready_idle", 32'(tready[u]), 32'd1);
        txd[u]    = d;
        tstart[u] = 1'b1;
        @(negedge clk);
        tstart[u] = 1'b0;
        chk("tx_load_high", 32'(txo[u]), 32'd1);
        chk("ready_busy", 32'(tready[u]), 32'd0);
        cap = '0;
        for (int k = 1; k <= nb; k++) begin
            @(negedge clk);
            cap = {cap[14:0], txo[u]};
            if (k == 3)  chk("ready_mid", 32'(tready[u]), 32'd0);
            if (k == nb) chk("ready_last_stop", 32'(tready[u]), 32'd1);
        end
    endtask

    // Drive one frame bit-by-bit onto u0's rx line.
    task automatic rx_frame(input logic [7:0] d, input logic par, input logic stp,
                            input logic [7:0] prev);
        @(negedge clk);
        rx_drv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_drv = d[i];
            if (i == 2) begin
                chk("rx_valid_clr", 32'(rvalid[0]), 32'd0);
                chk("rx_data_hold", 32'(rdata[0]), 32'(prev));
            end
        end
        @(negedge clk);
        rx_drv = par;
        @(negedge clk);
        rx_drv = stp;
        @(negedge clk);
        rx_drv = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cap;
        logic [7:0]  prev;
        logic [7:0]  rev;
        logic [11:0] exp12;
        logic        quiet;

        rxv[0] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        rxv[1] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0};
        rxv[2] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
        rxv[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
        rxv[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
        rxv[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
        rxv[6] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1};

        txv[0] = '{8'h00, 11'b0_00000000_0_1};
        txv[1] = '{8'h01, 11'b0_10000000_1_1};
        txv[2] = '{8'h5A, 11'b0_01011010_0_1};
        txv[3] = '{8'hFF, 11'b0_11111111_0_1};
        txv[4] = '{8'h80, 11'b0_00000001_1_1};
        txv[5] = '{8'h0F, 11'b0_11110000_0_1};

        txd    = '0;
        tstart = '0;
        lb     = 4'b1110;
        rx_drv = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx", 32'(txo), 32'hF);
        chk("rst_ready", 32'(tready), 32'hF);
        chk("rst_valid", 32'(rvalid), 32'h0);
        chk("rst_err", 32'(rerr), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Receive vectors driven directly onto u0's rx
        prev = 8'h00;
        for (int i = 0; i < 7; i++) begin
            rx_frame(rxv[i].d, rxv[i].par, rxv[i].stp, prev);
            chk("rx_data", 32'(rdata[0]), 32'(rxv[i].d));
            chk("rx_valid", 32'(rvalid[0]), 32'd1);
            chk("rx_err", 32'(rerr[0]),
                32'(rxv[i].exp_perr | (FRM_EN & rxv[i].exp_ferr)));
            prev = rxv[i].d;
        end

        // Transmit vectors on u0 with loopback into its own receiver
        @(negedge clk);
        lb[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_frame(0, txv[i].d, 11, cap);
            chk("tx_frame", 32'(cap[10:0]), 32'(txv[i].frame));
            @(negedge clk);
            chk("lb_data", 32'(rdata[0]), 32'(txv[i].d));
            chk("lb_valid", 32'(rvalid[0]), 32'd1);
            chk("lb_err", 32'(rerr[0]), 32'd0);
        end

        // Odd parity: 0x01 carries parity 0
        tx_frame(2, 8'h01, 11, cap);
        chk("odd_frame", 32'(cap[10:0]), 32'(11'b0_10000000_0_1));
        @(negedge clk);
        chk("odd_data", 32'(rdata[2]), 32'h01);
        chk("odd_err", 32'(rerr[2]), 32'd0);

        // No parity: 10-bit frame
        tx_frame(3, 8'h01, 10, cap);
        chk("none_frame", 32'(cap[9:0]), 32'(10'b0_10000000_1));
        @(negedge clk);
        chk("none_data", 32'(rdata[3]), 32'h01);
        chk("none_valid", 32'(rvalid[3]), 32'd1);

        // Two stop bits, back-to-back 0x00..0xFE with start held high
        @(negedge clk);
        txd[1]    = 8'h00;
        tstart[1] = 1'b1;
        for (int d = 0; d < 255; d++) begin
            @(negedge clk);
            chk("s2_load", 32'(txo[1]), 32'd1);
            cap = '0;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                cap = {cap[14:0], txo[1]};
            end
            for (int b = 0; b < 8; b++) rev[7-b] = d[b];
            exp12 = {1'b0, rev, ^d[7:0], 2'b11};
            chk("s2_frame", 32'(cap[11:0]), 32'(exp12));
            chk("s2_ready", 32'(tready[1]), 32'd1);
            chk("s2_data", 32'(rdata[1]), 32'(d[7:0]));
            chk("s2_valid", 32'(rvalid[1]), 32'd1);
            chk("s2_err", 32'(rerr[1]), 32'd0);
            if (d < 254) txd[1] = 8'(d + 1);
            else         tstart[1] = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Reset during data bit 3 of a u0 transmit of 0x00
        @(negedge clk);
        txd[0]    = 8'h00;
        tstart[0] = 1'b1;
        @(negedge clk);
        tstart[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_tx", 32'(txo[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(txo), 32'hF);
        chk("mid_rst_ready", 32'(tready), 32'hF);
        chk("mid_rst_valid", 32'(rvalid), 32'h0);
        chk("mid_rst_rdata", 32'(rdata), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (txo[0] !== 1'b1 || rvalid[0] !== 1'b0) quiet = 1'b0;
        end
        chk("post_rst_idle", 32'(quiet), 32'd1);

        // Normal operation after reset
        tx_frame(0, 8'hA5, 11, cap);
        chk("recov_frame", 32'(cap[10:0]), 32'(11'b0_10100101_0_1));
        @(negedge clk);
        chk("recov_data", 32'(rdata[0]), 32'hA5);
        chk("recov_valid", 32'(rvalid[0]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
